// File: rtl/dfe_pkg.sv
// Shared types and helpers for the PAM decision-feedback equaliser family.
package dfe_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } dfe_state_t;

    function automatic int acc_width(input int data_w, input int coef_w, input int n_taps);
        return data_w + coef_w + $clog2(n_taps) + 4;
    endfunction

    // Symbol index to signed amplitude: PAM4 {-3,-1,+1,+3}, PAM2 {-1,+1}.
    function automatic logic signed [2:0] pam_level(input int idx, input int pam_levels);
        logic signed [2:0] lvl;
        if (pam_levels == 2) begin
            lvl = (idx == 0) ? -3'sd1 : 3'sd1;
        end else begin
            lvl = 3'(2 * idx - 3);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/dfe_pam_slicer.sv
// Combinational PAM slicer: thresholds at 0 and +/-2*c0, ties go to the higher index.
module dfe_pam_slicer #(
    parameter int PAM_LEVELS = 4,
    parameter int ACC_W      = 32
) (
    input  logic signed [ACC_W-1:0]              y,
    input  logic signed [ACC_W-1:0]              c0,
    output logic        [$clog2(PAM_LEVELS)-1:0] sym
);

    if (PAM_LEVELS == 2) begin : g_pam2
        assign sym[0] = ~y[ACC_W-1];
    end else begin : g_pam4
        // One extra bit so 2*c0 and its negation cannot wrap.
        logic signed [ACC_W:0] y_ext;
        logic signed [ACC_W:0] thr;
        assign y_ext = {y[ACC_W-1], y};
        assign thr   = $signed({c0, 1'b0});

        always_comb begin
            sym = 2'd3;
            if (y_ext < -thr) begin
                sym = 2'd0;
            end else if (y_ext < 0) begin
                sym = 2'd1;
            end else if (y_ext < thr) begin
                sym = 2'd2;
            end
        end
    end

endmodule

// File: rtl/dfe_pam_eq.sv
// Parametrised PAM2/PAM4 decision-feedback equaliser with tap-load port and
// a stall-free streaming datapath.
module dfe_pam_eq
    import dfe_pkg::*;
#(
    parameter int N_TAPS     = 5,
    parameter int DATA_W     = 8,
    parameter int COEF_W     = 16,
    parameter int PAM_LEVELS = 4,
    parameter int SHIFT_W    = 4
) (
    input  logic                                                clk,
    input  logic                                                rstn,
    input  logic                                                cfg_we,
    input  logic        [$clog2(N_TAPS)-1:0]                    cfg_addr,
    input  logic signed [COEF_W-1:0]                            cfg_coef,
    input  logic        [SHIFT_W-1:0]                           cfg_shift,
    output logic                                                cfg_done,
    output logic                                                cfg_err,
    input  logic                                                flush,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic signed [DATA_W-1:0]                            in_data,
    output logic                                                out_valid,
    output logic        [$clog2(PAM_LEVELS)-1:0]                out_sym,
    output logic signed [acc_width(DATA_W, COEF_W, N_TAPS)-1:0] out_eq
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, N_TAPS);
    localparam int SYM_W = $clog2(PAM_LEVELS);
    localparam logic [SYM_W-1:0] SYM_PLUS1 = SYM_W'(PAM_LEVELS / 2);

    if (PAM_LEVELS != 2 && PAM_LEVELS != 4) begin : g_bad_pam
        $error("dfe_pam_eq: PAM_LEVELS must be 2 or 4");
    end

    dfe_state_t state_reg, state_next;
    logic [N_TAPS-1:0]        written_reg, written_next;
    logic signed [COEF_W-1:0] coef_reg [N_TAPS];
    logic [SHIFT_W-1:0]       shift_reg;
    logic                     cfg_err_reg;
    logic                     addr_ok, tap_wr;

    assign addr_ok = 32'(cfg_addr) < N_TAPS;
    assign tap_wr  = cfg_we && addr_ok && (state_reg == LOAD);

    always_comb begin
        written_next = written_reg;
        state_next   = state_reg;
        if (tap_wr) begin
            written_next[cfg_addr] = 1'b1;
        end
        if (state_reg == LOAD && (&written_next)) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= LOAD;
            written_reg <= '0;
            shift_reg   <= '0;
            cfg_err_reg <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                coef_reg[k] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            written_reg <= written_next;
            if (cfg_we && (!addr_ok || state_reg == RUN)) begin
                cfg_err_reg <= 1'b1;
            end
            if (tap_wr) begin
                coef_reg[cfg_addr] <= cfg_coef;
                if (cfg_addr == '0) begin
                    shift_reg <= cfg_shift;
                end
            end
        end
    end

    assign cfg_done = &written_reg;
    assign cfg_err  = cfg_err_reg;
    assign in_ready = (state_reg == RUN);

    // Datapath: x_reg (S1) -> decision + history (S2) -> output register.
    logic                                 v1_reg, v2_reg, out_valid_reg;
    logic signed [ACC_W-1:0]              x_reg, eq2_reg, out_eq_reg;
    logic [SYM_W-1:0]                     sym2_reg, out_sym_reg, s2_sym;
    logic [N_TAPS-1:1][SYM_W-1:0]         hist_reg, hist_eff, hist_shift, hist_next;
    logic signed [ACC_W-1:0]              isi_term [1:N_TAPS-1];
    logic signed [ACC_W-1:0]              isi_sum, y, c0_ext;

    // A flush overrides the history seen by the sample currently in S2.
    assign hist_eff = flush ? {(N_TAPS-1){SYM_PLUS1}} : hist_reg;
    assign c0_ext   = ACC_W'(coef_reg[0]);

    for (genvar gi = 1; gi < N_TAPS; gi++) begin : g_isi
        assign isi_term[gi] = ACC_W'(coef_reg[gi]) *
                              ACC_W'(pam_level(int'(hist_eff[gi]), PAM_LEVELS));
        if (gi == 1) begin : g_first
            assign hist_shift[gi] = s2_sym;
        end else begin : g_rest
            assign hist_shift[gi] = hist_eff[gi-1];
        end
    end

    always_comb begin
        isi_sum = '0;
        for (int k = 1; k < N_TAPS; k++) begin
            isi_sum = isi_sum + isi_term[k];
        end
    end

    assign y         = x_reg - isi_sum;
    assign hist_next = v1_reg ? hist_shift : hist_eff;

    dfe_pam_slicer #(
        .PAM_LEVELS (PAM_LEVELS),
        .ACC_W      (ACC_W)
    ) u_slicer (
        .y   (y),
        .c0  (c0_ext),
        .sym (s2_sym)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_reg        <= 1'b0;
            x_reg         <= '0;
            hist_reg      <= '0;
            v2_reg        <= 1'b0;
            sym2_reg      <= '0;
            eq2_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_sym_reg   <= '0;
            out_eq_reg    <= '0;
        end else begin
            v1_reg   <= in_valid && in_ready;
            if (in_valid && in_ready) begin
                x_reg <= ACC_W'(in_data) <<< shift_reg;
            end
            hist_reg <= hist_next;
            v2_reg   <= v1_reg;
            if (v1_reg) begin
                sym2_reg <= s2_sym;
                eq2_reg  <= y;
            end
            out_valid_reg <= v2_reg;
            if (v2_reg) begin
                out_sym_reg <= sym2_reg;
                out_eq_reg  <= eq2_reg;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sym   = out_sym_reg;
    assign out_eq    = out_eq_reg;

endmodule

// File: tb/tb_dfe_pam_eq.sv
// Scoreboard bench for dfe_pam_eq: a PAM4 and a PAM2 instance share stimulus.
module tb_dfe_pam_eq;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_addr = '0;
    logic signed [15:0] cfg_coef = '0;
    logic [3:0]        cfg_shift = '0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_data = '0;

    logic              cfg_done4, cfg_err4, in_ready4, out_valid4;
    logic [1:0]        out_sym4;
    logic signed [30:0] out_eq4;
    logic              cfg_done2, cfg_err2, in_ready2, out_valid2;
    logic [0:0]        out_sym2;
    logic signed [30:0] out_eq2;

    dfe_pam_eq #(.N_TAPS(5), .DATA_W(8), .COEF_W(16), .PAM_LEVELS(4), .SHIFT_W(4)) dut_4 (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_coef(cfg_coef),
        .cfg_shift(cfg_shift), .cfg_done(cfg_done4), .cfg_err(cfg_err4), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_sym(out_sym4), .out_eq(out_eq4));

    dfe_pam_eq #(.N_TAPS(5), .DATA_W(8), .COEF_W(16), .PAM_LEVELS(2), .SHIFT_W(4)) dut_2 (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_coef(cfg_coef),
        .cfg_shift(cfg_shift), .cfg_done(cfg_done2), .cfg_err(cfg_err2), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_sym(out_sym2), .out_eq(out_eq2));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_sel  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     sym;
        longint eq;
        int     cyc;
    } exp_t;

    exp_t sb_q[$];
    int   rx_q[$];

    // Reference model state.
    int     m_tap[5];
    int     m_hist[5];
    int     m_shift = 0;
    int     m_pam = 4;
    bit     m_pend = 1'b0;
    longint m_x = 0;
    int     m_acc_cyc = 0;

    function automatic int lvl(input int idx);
        if (m_pam == 2) return (idx != 0) ? 1 : -1;
        return 2 * idx - 3;
    endfunction

    task automatic model_s2();
        longint ym;
        int     d;
        ym = m_x;
        for (int k = 1; k < 5; k++) ym -= longint'(m_tap[k]) * lvl(m_hist[k]);
        if (m_pam == 2)                       d = (ym >= 0) ? 1 : 0;
        else if (ym < -2 * longint'(m_tap[0])) d = 0;
        else if (ym < 0)                      d = 1;
        else if (ym < 2 * longint'(m_tap[0])) d = 2;
        else                                  d = 3;
        sb_q.push_back('{d, ym, m_acc_cyc + 2});
        for (int k = 4; k > 1; k--) m_hist[k] = m_hist[k-1];
        m_hist[1] = d;
    endtask

    // Output monitor: pops the scoreboard and checks value and arrival cycle.
    logic   mon_ov;
    int     mon_os;
    longint mon_oe;
    exp_t   mon_e;
    always @(negedge clk) begin
        if (rstn) begin
            mon_ov = mon_sel ? out_valid2 : out_valid4;
            mon_os = mon_sel ? int'(out_sym2) : int'(out_sym4);
            mon_oe = mon_sel ? longint'(out_eq2) : longint'(out_eq4);
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                mon_e = sb_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_out_valid: no output at cycle %0d, required sym=%0d eq=%0d", mon_e.cyc, mon_e.sym, mon_e.eq);
            end
            if (mon_ov) begin
                rx_q.push_back(mon_os);
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_out_valid: out_valid=1 at cycle %0d, required 0", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_os !== mon_e.sym || mon_oe !== mon_e.eq || cyc !== mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL output: got sym=%0d eq=%0d cycle=%0d, required sym=%0d eq=%0d cycle=%0d",
                                 mon_os, mon_oe, cyc, mon_e.sym, mon_e.eq, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic clear_model();
        sb_q.delete();
        rx_q.delete();
        m_pend = 1'b0;
        for (int k = 0; k < 5; k++) begin
            m_hist[k] = 0;
            m_tap[k]  = 0;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1 clear_model();
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic write_tap(input int a, input int v, input int sh);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_coef = 16'(v); cfg_shift = 4'(sh);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic load_taps(input int c0, input int c1, input int c2, input int c3, input int c4, input int sh);
        int c[5];
        c = '{c0, c1, c2, c3, c4};
        for (int a = 0; a < 5; a++) begin
            write_tap(a, c[a], sh);
            m_tap[a] = c[a];
        end
        m_shift = sh;
    endtask

    // One clock of stream stimulus; advances the reference model by the same cycle.
    task automatic cyc_drive(input bit v, input int d, input bit fl);
        bit acc;
        in_valid = v; in_data = 8'(d); flush = fl;
        acc = v && (mon_sel ? in_ready2 : in_ready4);
        if (fl) for (int k = 1; k < 5; k++) m_hist[k] = m_pam / 2;
        if (m_pend) model_s2();
        m_pend = acc;
        if (acc) begin
            m_x = longint'(d) * (longint'(1) << m_shift);
            m_acc_cyc = cyc + 1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) cyc_drive(1'b0, 0, 1'b0);
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1 clear_model();
        n_checks += 6;
        if (cfg_done4 !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_done: got %b, required 0", cfg_done4); end
        if (cfg_err4 !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b, required 0", cfg_err4); end
        if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 0", in_ready4); end
        if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid4); end
        if (out_sym4 !== 2'd0) begin n_fail++; $display("FAIL reset_out_sym: got %0d, required 0", out_sym4); end
        if (out_eq4 !== 31'sd0) begin n_fail++; $display("FAIL reset_out_eq: got %0d, required 0", out_eq4); end
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL post_reset_in_ready: got %b, required 0", in_ready4); end
    endtask

    task automatic test_basic_pam4();
        int seq[4];
        do_reset();
        load_taps(64, 0, 0, 0, 0, 6);
        n_checks += 2;
        if (cfg_done4 !== 1'b1) begin n_fail++; $display("FAIL basic_cfg_done: got %b, required 1", cfg_done4); end
        if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b, required 1", in_ready4); end
        seq = '{3, 1, -1, -3};
        for (int i = 0; i < 4; i++) cyc_drive(1'b1, seq[i], 1'b0);
        drain();
        n_checks++;
        if (rx_q.size() != 4 || rx_q[0] != 3 || rx_q[1] != 2 || rx_q[2] != 1 || rx_q[3] != 0) begin
            n_fail++;
            $display("FAIL basic_syms: got %0d symbols, required 3,2,1,0", rx_q.size());
        end
    endtask

    task automatic test_prbs_isi();
        logic [6:0] lfsr;
        int tx_q[$];
        int s, l, lprev, errs;
        do_reset();
        load_taps(64, 32, 0, 0, 0, 6);
        cyc_drive(1'b0, 0, 1'b1);
        rx_q.delete();
        lfsr = 7'h01;
        lprev = 1;
        for (int i = 0; i < 127; i++) begin
            lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            s = int'(lfsr[1:0]);
            l = 2 * s - 3;
            cyc_drive(1'b1, l + (lprev >>> 1), 1'b0);
            tx_q.push_back(s);
            lprev = l;
        end
        drain();
        errs = 0;
        for (int i = 0; i < 127 && i < rx_q.size(); i++) if (rx_q[i] != tx_q[i]) errs++;
        n_checks += 2;
        if (rx_q.size() != 127) begin n_fail++; $display("FAIL prbs_count: got %0d symbols, required 127", rx_q.size()); end
        if (errs != 0) begin n_fail++; $display("FAIL prbs_errors: got %0d symbol errors, required 0", errs); end
    endtask

    task automatic test_cfg_protect();
        do_reset();
        write_tap(0, 64, 6); m_tap[0] = 64; m_shift = 6;
        write_tap(1, 16, 6); m_tap[1] = 16;
        write_tap(2, 0, 6);
        write_tap(3, 0, 6);
        n_checks += 2;
        if (cfg_done4 !== 1'b0) begin n_fail++; $display("FAIL partial_cfg_done: got %b, required 0", cfg_done4); end
        if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL partial_in_ready: got %b, required 0", in_ready4); end
        cyc_drive(1'b1, 5, 1'b0);
        cyc_drive(1'b1, -5, 1'b0);
        write_tap(4, 0, 6);
        n_checks += 3;
        if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL full_in_ready: got %b, required 1", in_ready4); end
        if (cfg_done4 !== 1'b1) begin n_fail++; $display("FAIL full_cfg_done: got %b, required 1", cfg_done4); end
        if (cfg_err4 !== 1'b0) begin n_fail++; $display("FAIL load_cfg_err: got %b, required 0", cfg_err4); end
        write_tap(2, 100, 6);
        n_checks++;
        if (cfg_err4 !== 1'b1) begin n_fail++; $display("FAIL run_write_cfg_err: got %b, required 1", cfg_err4); end
        for (int i = 0; i < 8; i++) cyc_drive(1'b1, $urandom_range(0, 8) - 4, 1'b0);
        drain();
    endtask

    task automatic test_addr_range();
        do_reset();
        write_tap(5, 77, 2);
        n_checks += 2;
        if (cfg_err4 !== 1'b1) begin n_fail++; $display("FAIL range_cfg_err: got %b, required 1", cfg_err4); end
        if (cfg_done4 !== 1'b0) begin n_fail++; $display("FAIL range_cfg_done: got %b, required 0", cfg_done4); end
    endtask

    task automatic test_pam2();
        int seq[6];
        mon_sel = 1'b1;
        m_pam = 2;
        do_reset();
        load_taps(64, 0, 0, 0, 0, 6);
        seq = '{0, -1, 1, -128, 127, 0};
        for (int i = 0; i < 6; i++) cyc_drive(1'b1, seq[i], 1'b0);
        drain();
        n_checks++;
        if (rx_q.size() != 6 || rx_q[0] != 1 || rx_q[1] != 0) begin
            n_fail++;
            $display("FAIL pam2_tie: got %0d symbols, required first two 1,0", rx_q.size());
        end
        mon_sel = 1'b0;
        m_pam = 4;
    endtask

    task automatic test_gaps_flush();
        do_reset();
        load_taps(64, 32, -16, 8, 4, 3);
        for (int i = 0; i < 40; i++) begin
            cyc_drive((i % 2) == 0, $urandom_range(0, 200) - 100, (i == 17) || (i == 24));
        end
        drain();
        n_checks++;
        if (rx_q.size() != 20) begin n_fail++; $display("FAIL gap_count: got %0d outputs, required 20", rx_q.size()); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        load_taps(64, 32, 0, 0, 0, 6);
        for (int i = 0; i < 6; i++) cyc_drive(1'b1, 2, 1'b0);
        n_checks++;
        if (out_valid4 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_out_valid: got %b, required 1", out_valid4); end
        rstn = 1'b0;
        #1 clear_model();
        n_checks += 3;
        if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b, required 0", out_valid4); end
        if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL midreset_in_ready: got %b, required 0", in_ready4); end
        if (cfg_done4 !== 1'b0) begin n_fail++; $display("FAIL midreset_cfg_done: got %b, required 0", cfg_done4); end
        @(posedge clk);
        #1 rstn = 1'b1;
        cyc_drive(1'b1, 2, 1'b0);
        drain();
        n_checks++;
        if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL after_reset_load_state: in_ready got %b, required 0", in_ready4); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic_pam4();
        test_prbs_isi();
        test_cfg_protect();
        test_addr_range();
        test_pam2();
        test_gaps_flush();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
